mode7_frame_sequencer: RTL and testbench
========================================

Name: mode7_frame_sequencer

Overview:
- Consumes the 60 Hz square wave from the frame-rate clock divider.
- Turns each rising edge into one frame: advances the Mode 7 camera parameters (angle, scroll X/Y, frame number) and offers them to the Mode 7 renderer over a valid/ready handshake, then waits for the renderer's render-done.
- Detects frames the renderer could not keep up with and counts them.

Parameters:
- ANGLE_W, 8, width of the rotation angle accumulator (full turn = 2^ANGLE_W).
- POS_W, 16, width of the scroll position registers (unsigned, wrap-around).
- VEL_W, 8, width of the signed per-frame velocity inputs.
- FRAME_W, 16, width of the frame number counter.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-low reset.
- tick_in  in  1  60 Hz square wave from the frame-rate divider, same clock domain.
- enable  in  1  when high, rising edges of tick_in start frames.
- angle_step  in  ANGLE_W  unsigned angle increment per frame.
- vel_x  in  VEL_W  signed scroll X increment per frame.
- vel_y  in  VEL_W  signed scroll Y increment per frame.
- frame_valid  out  1  frame parameters offered to the renderer.
- frame_ready  in  1  renderer accepts the offered frame.
- render_done  in  1  one-cycle pulse: renderer finished the accepted frame.
- frame_num  out  FRAME_W  number of the current or most recent frame.
- angle  out  ANGLE_W  current rotation angle.
- pos_x  out  POS_W  current scroll X.
- pos_y  out  POS_W  current scroll Y.
- busy  out  1  high when the state is not IDLE.
- overrun_cnt  out  OVR_W  number of dropped ticks, saturating.

Behaviour:
- Reset (reset low at a clk edge):
  - state = IDLE.
  - frame_valid, busy, frame_num, angle, pos_x, pos_y, overrun_cnt = 0.
  - Edge-detect register tick_d = 1. The divider output is high straight out of reset, so no false edge is seen.
  - Reset asserted mid-frame aborts the frame immediately; there is no residual handshake.
- Edge detect:
  - rise = tick_in & ~tick_d, registered compare.
  - An output update happens on the cycle after the clk edge where rise is seen (1-cycle latency).
- IDLE:
  - On rise with enable=1, in a single cycle:
    - angle += angle_step, mod 2^ANGLE_W.
    - pos_x += sign-extended vel_x, mod 2^POS_W.
    - pos_y += sign-extended vel_y, mod 2^POS_W.
    - frame_num += 1, wrapping at 2^FRAME_W.
    - frame_valid set to 1; go to REQ.
  - On rise with enable=0: ignored; no overrun counted.
  - render_done and frame_ready are ignored.
- REQ:
  - frame_valid=1. angle, pos_x, pos_y and frame_num are held stable.
  - frame_ready=1 at a clk edge: transfer occurs; frame_valid drops next cycle; go to BUSY.
  - render_done is ignored.
- BUSY:
  - frame_valid=0. Outputs are held.
  - render_done=1: go to IDLE.
- Overrun:
  - rise while in REQ or BUSY increments overrun_cnt, saturating at 2^OVR_W-1.
  - No parameter update and no queued frame result from that tick.
- Simultaneous events:
  - rise + frame_ready in REQ: accept (go to BUSY) and count an overrun.
  - rise + render_done in BUSY: go to IDLE and count an overrun. The tick is dropped, not replayed.
- enable falling mid-frame: the current frame completes normally; subsequent ticks are ignored.
- busy is a combinational decode of state (state != IDLE).
- Velocity and angle_step are sampled only on the starting edge.

Test Plan:
- Reset released with tick_in=1, no toggling for 100 cycles -> frame_valid stays 0, all outputs 0.
- enable=1, angle_step=0x10, vel_x=+3, vel_y=-2 (0xFE); one tick rise; frame_ready=1 immediately; render_done 5 cycles later -> frame_valid high for 1 cycle.
  - Outputs: angle=0x10, pos_x=3, pos_y=0xFFFE, frame_num=1, busy low after done.
- angle_step=0x40, 5 frames completed -> angle wraps to 0x40. Then vel_x=-1 from pos_x=0 -> pos_x=0xFFFF.
- frame_ready held 0; 3 further tick rises -> frame_valid stays 1, outputs unchanged, overrun_cnt=3.
  - Then ready=1 and done -> IDLE, frame_num unchanged.
- rise coincident with render_done in BUSY -> IDLE, overrun_cnt+1, no new frame_valid.
  - 300 forced overruns -> overrun_cnt saturates at 255.
- reset pulsed low while in BUSY -> next cycle: state IDLE, all outputs 0.
  - enable=0 with ticks -> no frames, overrun_cnt stays 0.

Source files
------------

// File: rtl/mode7_frame_sequencer.sv
// Mode 7 frame sequencer: turns rising edges of the 60 Hz frame tick into camera
// parameter updates handed to the renderer over valid/ready, and counts dropped ticks.
module mode7_frame_sequencer #(
    parameter int unsigned ANGLE_W = 8,
    parameter int unsigned POS_W   = 16,
    parameter int unsigned VEL_W   = 8,
    parameter int unsigned FRAME_W = 16,
    parameter int unsigned OVR_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_in,
    input  logic               enable,
    input  logic [ANGLE_W-1:0] angle_step,
    input  logic [VEL_W-1:0]   vel_x,
    input  logic [VEL_W-1:0]   vel_y,
    output logic               frame_valid,
    input  logic               frame_ready,
    input  logic               render_done,
    output logic [FRAME_W-1:0] frame_num,
    output logic [ANGLE_W-1:0] angle,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic               busy,
    output logic [OVR_W-1:0]   overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               tick_q;
    logic               valid_q, valid_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [POS_W-1:0]   pos_x_q, pos_x_d;
    logic [POS_W-1:0]   pos_y_q, pos_y_d;
    logic [OVR_W-1:0]   ovr_q, ovr_d;

    logic               rise;
    logic [POS_W-1:0]   vx_ext;
    logic [POS_W-1:0]   vy_ext;

    assign rise   = tick_in & ~tick_q;
    assign vx_ext = POS_W'($signed(vel_x));
    assign vy_ext = POS_W'($signed(vel_y));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            // Divider output is high out of reset; start high so no false edge.
            tick_q  <= 1'b1;
            valid_q <= 1'b0;
            frame_q <= '0;
            angle_q <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_in;
            valid_q <= valid_d;
            frame_q <= frame_d;
            angle_q <= angle_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        frame_d = frame_q;
        angle_d = angle_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            IDLE: begin
                if (rise && enable) begin
                    angle_d = angle_q + angle_step;
                    pos_x_d = pos_x_q + vx_ext;
                    pos_y_d = pos_y_q + vy_ext;
                    frame_d = frame_q + FRAME_W'(1);
                    valid_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (frame_ready) begin
                    valid_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (render_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A tick arriving mid-frame is dropped, never queued.
        if (rise && (state_q != IDLE) && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    assign frame_valid = valid_q;
    assign frame_num   = frame_q;
    assign angle       = angle_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign busy        = (state_q != IDLE);
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_mode7_frame_sequencer.sv
// Directed self-checking bench for mode7_frame_sequencer with hand-computed expectations.
module tb_mode7_frame_sequencer;

    logic        clk;
    logic        reset;
    logic        tick_in;
    logic        enable;
    logic [7:0]  angle_step;
    logic [7:0]  vel_x;
    logic [7:0]  vel_y;
    logic        frame_valid;
    logic        frame_ready;
    logic        render_done;
    logic [15:0] frame_num;
    logic [7:0]  angle;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic        busy;
    logic [7:0]  overrun_cnt;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned valid_seen;

    mode7_frame_sequencer #(
        .ANGLE_W (8),
        .POS_W   (16),
        .VEL_W   (8),
        .FRAME_W (16),
        .OVR_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_in     (tick_in),
        .enable      (enable),
        .angle_step  (angle_step),
        .vel_x       (vel_x),
        .vel_y       (vel_y),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .render_done (render_done),
        .frame_num   (frame_num),
        .angle       (angle),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rise_tick();
        tick_in = 1'b0;
        cyc();
        tick_in = 1'b1;
        cyc();
    endtask

    task automatic run_frame();
        frame_ready = 1'b1;
        rise_tick();
        cyc();
        render_done = 1'b1;
        cyc();
        render_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        valid_seen  = 0;
        reset       = 1'b0;
        tick_in     = 1'b1;
        enable      = 1'b0;
        angle_step  = '0;
        vel_x       = '0;
        vel_y       = '0;
        frame_ready = 1'b0;
        render_done = 1'b0;
        do_reset();

        // Idle after reset with tick held high
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (frame_valid) valid_seen++;
        end
        check("idle_valid_seen", valid_seen, 0);
        check("idle_busy", busy, 0);
        check("idle_frame", frame_num, 0);
        check("idle_angle", angle, 0);
        check("idle_posx", pos_x, 0);
        check("idle_posy", pos_y, 0);
        check("idle_ovr", overrun_cnt, 0);

        // Single frame
        enable      = 1'b1;
        angle_step  = 8'h10;
        vel_x       = 8'h03;
        vel_y       = 8'hFE;
        frame_ready = 1'b1;
        rise_tick();
        check("f1_valid", frame_valid, 1);
        check("f1_angle", angle, 8'h10);
        check("f1_posx", pos_x, 16'h0003);
        check("f1_posy", pos_y, 16'hFFFE);
        check("f1_frame", frame_num, 1);
        cyc();
        check("f1_valid_drop", frame_valid, 0);
        check("f1_busy", busy, 1);
        cyc(); cyc(); cyc();
        render_done = 1'b1;
        cyc();
        render_done = 1'b0;
        check("f1_done_busy", busy, 0);
        check("f1_done_angle", angle, 8'h10);

        // Angle wrap and negative velocity wrap
        do_reset();
        angle_step = 8'h40;
        vel_x      = 8'h00;
        vel_y      = 8'h00;
        for (int i = 0; i < 5; i++) run_frame();
        check("wrap_angle", angle, 8'h40);
        check("wrap_frame", frame_num, 5);
        check("wrap_posx0", pos_x, 0);
        vel_x = 8'hFF;
        run_frame();
        check("neg_posx", pos_x, 16'hFFFF);
        check("neg_angle", angle, 8'h80);
        check("neg_frame", frame_num, 6);

        // Renderer stalls ready; three ticks dropped
        frame_ready = 1'b0;
        rise_tick();
        check("stall_valid", frame_valid, 1);
        check("stall_frame", frame_num, 7);
        for (int i = 0; i < 3; i++) rise_tick();
        check("stall_valid_held", frame_valid, 1);
        check("stall_angle", angle, 8'hC0);
        check("stall_posx", pos_x, 16'hFFFE);
        check("stall_frame_held", frame_num, 7);
        check("stall_ovr", overrun_cnt, 3);
        frame_ready = 1'b1;
        cyc();
        check("stall_accept_valid", frame_valid, 0);
        render_done = 1'b1;
        cyc();
        render_done = 1'b0;
        check("stall_done_busy", busy, 0);
        check("stall_done_frame", frame_num, 7);

        // Tick coincident with render_done in BUSY
        rise_tick();
        cyc();
        check("coin_busy_pre", busy, 1);
        tick_in = 1'b0;
        cyc();
        tick_in     = 1'b1;
        render_done = 1'b1;
        cyc();
        render_done = 1'b0;
        check("coin_busy", busy, 0);
        check("coin_ovr", overrun_cnt, 4);
        cyc();
        check("coin_no_valid", frame_valid, 0);
        check("coin_frame", frame_num, 8);
        check("coin_angle", angle, 8'h00);

        // Saturation of the overrun counter
        frame_ready = 1'b0;
        rise_tick();
        for (int i = 0; i < 300; i++) rise_tick();
        check("sat_ovr", overrun_cnt, 8'hFF);
        check("sat_frame", frame_num, 9);
        frame_ready = 1'b1;
        cyc();
        render_done = 1'b1;
        cyc();
        render_done = 1'b0;

        // enable dropped mid-frame: frame finishes, later ticks ignored
        frame_ready = 1'b0;
        rise_tick();
        enable      = 1'b0;
        frame_ready = 1'b1;
        cyc();
        render_done = 1'b1;
        cyc();
        render_done = 1'b0;
        check("endis_busy", busy, 0);
        rise_tick();
        check("endis_valid", frame_valid, 0);
        check("endis_frame", frame_num, 10);

        // Reset asserted while BUSY
        enable = 1'b1;
        rise_tick();
        cyc();
        check("rst_busy_pre", busy, 1);
        reset = 1'b0;
        cyc();
        check("rst_busy", busy, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_frame", frame_num, 0);
        check("rst_angle", angle, 0);
        check("rst_posx", pos_x, 0);
        check("rst_ovr", overrun_cnt, 0);
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) rise_tick();
        check("dis_valid", frame_valid, 0);
        check("dis_frame", frame_num, 0);
        check("dis_ovr", overrun_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
